// File: rtl/fifo_ptr_ctrl.sv
// Single-clock FIFO pointer controller: Gray-coded read/write pointers, memory strobes/addresses,
// full/empty/count status. Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow flags.

module gray_to_binary #(
  parameter int W = 4
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);
  // Each binary bit is the XOR of all Gray bits at or above it; no chained net.
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^gray[W-1:i];
  end
endmodule

module fifo_ptr_ctrl #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_req,
  input  logic              rd_req,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   wr_ptr_gray,
  output logic [ADDR_W:0]   rd_ptr_gray,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic              overflow,
  output logic              underflow
`endif
);
  localparam int PW = ADDR_W + 1;
  // Full when the top two Gray bits differ and the rest match; valid for ADDR_W == 1 too.
  localparam logic [ADDR_W:0] FULL_MASK = PW'(3) << (ADDR_W - 1);

  logic [ADDR_W:0] wr_ptr_gray_q, wr_ptr_gray_d;
  logic [ADDR_W:0] rd_ptr_gray_q, rd_ptr_gray_d;
  logic [ADDR_W:0] wr_bin, rd_bin, wr_bin_inc, rd_bin_inc;
  logic            push, pop;

  gray_to_binary #(.W(PW)) u_wr_g2b (.gray(wr_ptr_gray_q), .bin(wr_bin));
  gray_to_binary #(.W(PW)) u_rd_g2b (.gray(rd_ptr_gray_q), .bin(rd_bin));

  assign empty = (wr_ptr_gray_q == rd_ptr_gray_q);
  assign full  = (wr_ptr_gray_q == (rd_ptr_gray_q ^ FULL_MASK));
  assign count = wr_bin - rd_bin;

  // Strobes are held low while reset is asserted, even with requests pending.
  assign push = wr_req & ~full & rst_n;
  assign pop  = rd_req & ~empty & rst_n;

  assign wr_en       = push;
  assign rd_en       = pop;
  assign wr_addr     = wr_bin[ADDR_W-1:0];
  assign rd_addr     = rd_bin[ADDR_W-1:0];
  assign wr_ptr_gray = wr_ptr_gray_q;
  assign rd_ptr_gray = rd_ptr_gray_q;

  assign wr_bin_inc = wr_bin + PW'(1);
  assign rd_bin_inc = rd_bin + PW'(1);

  always_comb begin
    wr_ptr_gray_d = wr_ptr_gray_q;
    rd_ptr_gray_d = rd_ptr_gray_q;
    if (push) wr_ptr_gray_d = wr_bin_inc ^ (wr_bin_inc >> 1);
    if (pop)  rd_ptr_gray_d = rd_bin_inc ^ (rd_bin_inc >> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_gray_q <= '0;
      rd_ptr_gray_q <= '0;
    end else begin
      wr_ptr_gray_q <= wr_ptr_gray_d;
      rd_ptr_gray_q <= rd_ptr_gray_d;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q  | (wr_req & full);
    underflow_d = underflow_q | (rd_req & empty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  // Without error flags, rejected requests are simply dropped.
`endif

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Directed bench for fifo_ptr_ctrl with ADDR_W = 2 (DEPTH = 4); hand-computed expectations.

module tb_fifo_ptr_ctrl;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_req, rd_req;
  logic          wr_en, rd_en, full, empty;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [AW:0]   wr_ptr_gray, rd_ptr_gray, count;
`ifdef FIFO_ERR_FLAGS_EN
  logic          overflow, underflow;
`endif

  int checks   = 0;
  int failures = 0;

  fifo_ptr_ctrl #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_req     (wr_req),
    .rd_req     (rd_req),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .wr_ptr_gray(wr_ptr_gray),
    .rd_ptr_gray(rd_ptr_gray),
    .full       (full),
    .empty      (empty),
    .count      (count)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .overflow   (overflow),
    .underflow  (underflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply requests mid-low-phase, then settle before sampling strobes.
  task automatic drive(input logic w, input logic r);
    @(negedge clk);
    wr_req = w;
    rd_req = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [AW:0] fill_gray [4];
  logic [AW:0] wrap_gray [6];

  initial begin
    fill_gray = '{3'b001, 3'b011, 3'b010, 3'b110};
    wrap_gray = '{3'b111, 3'b101, 3'b100, 3'b000, 3'b001, 3'b011};
    rst_n  = 1'b0;
    wr_req = 1'b0;
    rd_req = 1'b0;

    // Reset state before any clock edge
    #2;
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_wptr", 32'(wr_ptr_gray), 0);
    chk("rst_rptr", 32'(rd_ptr_gray), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill to full
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0);
      chk("fill_wr_en", 32'(wr_en), 1);
      chk("fill_wr_addr", 32'(wr_addr), 32'(i));
      tick();
      chk("fill_wptr", 32'(wr_ptr_gray), 32'(fill_gray[i]));
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_empty", 32'(empty), 0);
    end
    chk("fill_full", 32'(full), 1);
`ifdef FIFO_ERR_FLAGS_EN
    chk("ovf_pre", 32'(overflow), 0);
`endif
    drive(1'b1, 1'b0);
    chk("push_full_wr_en", 32'(wr_en), 0);
    tick();
    chk("push_full_wptr", 32'(wr_ptr_gray), 3'b110);
    chk("push_full_count", 32'(count), 4);
`ifdef FIFO_ERR_FLAGS_EN
    chk("ovf_set", 32'(overflow), 1);
`endif

    // Drain
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1);
      chk("drain_rd_en", 32'(rd_en), 1);
      chk("drain_rd_addr", 32'(rd_addr), 32'(i));
      tick();
      chk("drain_count", 32'(count), 32'(3 - i));
      chk("drain_full", 32'(full), 0);
    end
    chk("drain_empty", 32'(empty), 1);
`ifdef FIFO_ERR_FLAGS_EN
    chk("unf_pre", 32'(underflow), 0);
`endif
    drive(1'b0, 1'b1);
    chk("pop_empty_rd_en", 32'(rd_en), 0);
    tick();
    chk("pop_empty_rptr", 32'(rd_ptr_gray), 3'b110);
`ifdef FIFO_ERR_FLAGS_EN
    chk("unf_set", 32'(underflow), 1);
    chk("ovf_sticky", 32'(overflow), 1);
`endif

    // Wrap-around: pointers start at binary 4, addresses run 0,1,2,3,0,1
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0);
      chk("wrap_wr_addr", 32'(wr_addr), 32'(i % 4));
      tick();
      chk("wrap_wptr", 32'(wr_ptr_gray), 32'(wrap_gray[i]));
      chk("wrap_empty_after_push", 32'(empty), 0);
      chk("wrap_full_after_push", 32'(full), 0);
      drive(1'b0, 1'b1);
      chk("wrap_rd_addr", 32'(rd_addr), 32'(i % 4));
      tick();
      chk("wrap_rptr", 32'(rd_ptr_gray), 32'(wrap_gray[i]));
      chk("wrap_empty_after_pop", 32'(empty), 1);
    end

    // Simultaneous at count 2 (pointers at binary 2 -> wr 4)
    drive(1'b1, 1'b0); tick();
    drive(1'b1, 1'b0); tick();
    chk("sim2_count_pre", 32'(count), 2);
    drive(1'b1, 1'b1);
    chk("sim2_wr_en", 32'(wr_en), 1);
    chk("sim2_rd_en", 32'(rd_en), 1);
    chk("sim2_wr_addr", 32'(wr_addr), 0);
    chk("sim2_rd_addr", 32'(rd_addr), 2);
    tick();
    chk("sim2_count", 32'(count), 2);

    // Simultaneous at full
    drive(1'b1, 1'b0); tick();
    drive(1'b1, 1'b0); tick();
    chk("simf_full_pre", 32'(full), 1);
    drive(1'b1, 1'b1);
    chk("simf_wr_en", 32'(wr_en), 0);
    chk("simf_rd_en", 32'(rd_en), 1);
    tick();
    chk("simf_count", 32'(count), 3);
    chk("simf_full", 32'(full), 0);

    // Simultaneous at empty
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1); tick();
    end
    chk("sime_empty_pre", 32'(empty), 1);
    drive(1'b1, 1'b1);
    chk("sime_wr_en", 32'(wr_en), 1);
    chk("sime_rd_en", 32'(rd_en), 0);
    tick();
    chk("sime_count", 32'(count), 1);

    // Reset mid-operation at count 3, asserted away from any edge
    drive(1'b1, 1'b0); tick();
    drive(1'b1, 1'b0); tick();
    chk("mid_count_pre", 32'(count), 3);
    drive(1'b1, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_empty", 32'(empty), 1);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_wptr", 32'(wr_ptr_gray), 0);
    chk("mid_rst_rptr", 32'(rd_ptr_gray), 0);
    chk("mid_rst_wr_en", 32'(wr_en), 0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("mid_rst_ovf", 32'(overflow), 0);
    chk("mid_rst_unf", 32'(underflow), 0);
`endif
    drive(1'b0, 1'b0);
    rst_n = 1'b1;
    drive(1'b1, 1'b0);
    chk("post_rst_wr_en", 32'(wr_en), 1);
    chk("post_rst_wr_addr", 32'(wr_addr), 0);
    tick();
    chk("post_rst_count", 32'(count), 1);
    drive(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
